// File: rtl/pc_fetch_unit.sv
// Instruction-fetch front end: PC register, single-outstanding imem request FSM
// and a 2-entry {pc,instr} buffer feeding decode, with redirect squashing.
module pc_fetch_unit #(
    parameter int             N        = 32,
    parameter logic [N-1:0]   RESET_PC = '0
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_redirect,
    input  logic [N-1:0]  i_redirect_pc,
    output logic          o_imem_req,
    output logic [N-1:0]  o_imem_addr,
    input  logic          i_imem_ack,
    input  logic [31:0]   i_imem_rdata,
    output logic          o_if_valid,
    output logic [N-1:0]  o_if_pc,
    output logic [31:0]   o_if_instr,
    input  logic          i_id_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DROP  = 2'd3
    } state_t;

    localparam logic [N-1:0] PC_STEP = N'(4);
    localparam logic [31:0]  NOP     = 32'h0000_0013;

    state_t       r_state;
    logic         r_req;
    logic [N-1:0] r_pc;
    logic [N-1:0] r_pend_pc;
    logic [1:0]   r_count;
    logic [N-1:0] r_hd_pc;
    logic [31:0]  r_hd_instr;
    logic [N-1:0] r_b1_pc;
    logic [31:0]  r_b1_instr;

    logic         w_ack;
    logic         w_push;
    logic         w_pop;
    logic [1:0]   w_count_nxt;

    // An ack only counts while a request is actually outstanding.
    assign w_ack  = i_imem_ack & r_req;
    assign w_push = w_ack & (r_state == FETCH) & ~i_redirect;
    assign w_pop  = (r_count != 2'd0) & i_id_ready & ~i_redirect;

    // Buffer occupancy after this cycle's push/pop/flush.
    always_comb begin
        w_count_nxt = r_count;
        if (i_redirect) begin
            w_count_nxt = 2'd0;
        end else if (w_push && !w_pop) begin
            w_count_nxt = r_count + 2'd1;
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - 2'd1;
        end else begin
            w_count_nxt = r_count;
        end
    end

    // Two-entry buffer: head register drives decode, second slot shifts in on pop.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count    <= 2'd0;
            r_hd_pc    <= '0;
            r_hd_instr <= NOP;
            r_b1_pc    <= '0;
            r_b1_instr <= NOP;
        end else begin
            r_count <= w_count_nxt;
            if (w_push) begin
                if (r_count == 2'd0 || (r_count == 2'd1 && w_pop)) begin
                    r_hd_pc    <= r_pc;
                    r_hd_instr <= i_imem_rdata;
                end else if (r_count == 2'd1) begin
                    r_b1_pc    <= r_pc;
                    r_b1_instr <= i_imem_rdata;
                end else begin
                    r_hd_pc    <= r_b1_pc;
                    r_hd_instr <= r_b1_instr;
                    r_b1_pc    <= r_pc;
                    r_b1_instr <= i_imem_rdata;
                end
            end else if (w_pop && r_count == 2'd2) begin
                r_hd_pc    <= r_b1_pc;
                r_hd_instr <= r_b1_instr;
            end
        end
    end

    // Fetch FSM; r_pc stays at the in-flight address while in DROP so imem_addr is stable.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_req     <= 1'b0;
            r_pc      <= RESET_PC;
            r_pend_pc <= RESET_PC;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state <= FETCH;
                    r_req   <= 1'b1;
                    if (i_redirect) begin
                        r_pc <= i_redirect_pc;
                    end
                end
                FETCH: begin
                    if (i_redirect) begin
                        if (w_ack) begin
                            r_pc <= i_redirect_pc;
                        end else begin
                            r_pend_pc <= i_redirect_pc;
                            r_state   <= DROP;
                        end
                    end else if (w_ack) begin
                        r_pc <= r_pc + PC_STEP;
                        if (w_count_nxt == 2'd2) begin
                            r_state <= HOLD;
                            r_req   <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (i_redirect) begin
                        r_pc    <= i_redirect_pc;
                        r_state <= FETCH;
                        r_req   <= 1'b1;
                    end else if (w_count_nxt != 2'd2) begin
                        r_state <= FETCH;
                        r_req   <= 1'b1;
                    end
                end
                DROP: begin
                    if (i_redirect) begin
                        r_pend_pc <= i_redirect_pc;
                    end
                    if (w_ack) begin
                        r_pc    <= i_redirect ? i_redirect_pc : r_pend_pc;
                        r_state <= FETCH;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign o_imem_req  = r_req;
    assign o_imem_addr = r_pc;
    assign o_if_valid  = (r_count != 2'd0);
    assign o_if_pc     = r_hd_pc;
    assign o_if_instr  = r_hd_instr;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: expected {pc,instr} pairs are queued when an
// ack is driven and compared against if_* when decode pops the head.
module tb_pc_fetch_unit;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_ack;
    logic [31:0] i_imem_rdata;
    logic        o_if_valid;
    logic [31:0] o_if_pc;
    logic [31:0] o_if_instr;
    logic        i_id_ready;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;
    entry_t sb_q[$];

    pc_fetch_unit #(.N(32), .RESET_PC(32'h0)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_ack    (i_imem_ack),
        .i_imem_rdata  (i_imem_rdata),
        .o_if_valid    (o_if_valid),
        .o_if_pc       (o_if_pc),
        .o_if_instr    (o_if_instr),
        .i_id_ready    (i_id_ready)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return 32'hC0DE_0000 ^ {a[15:0], a[31:16]} ^ 32'h0000_0033;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard the head if decode takes it this cycle, then advance one clock.
    task automatic cyc();
        entry_t e;
        if (o_if_valid && i_id_ready && !i_redirect) begin
            check("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("sb_pc", o_if_pc, e.pc);
                check("sb_instr", o_if_instr, e.instr);
            end
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic ack_push(input logic [31:0] a);
        entry_t e;
        i_imem_ack   = 1'b1;
        i_imem_rdata = instr_of(a);
        e.pc    = a;
        e.instr = instr_of(a);
        sb_q.push_back(e);
    endtask

    initial begin
        i_rst = 1'b1; i_redirect = 1'b0; i_redirect_pc = 32'h0;
        i_imem_ack = 1'b0; i_imem_rdata = 32'h0; i_id_ready = 1'b1;
        #1;
        check("rst_req", 32'(o_imem_req), 32'd0);
        check("rst_addr", o_imem_addr, 32'h0);
        check("rst_valid", 32'(o_if_valid), 32'd0);
        check("rst_if_pc", o_if_pc, 32'h0);
        check("rst_if_instr", o_if_instr, 32'h0000_0013);
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        check("idle_req", 32'(o_imem_req), 32'd0);
        cyc();
        check("first_req", 32'(o_imem_req), 32'd1);

        // Back-to-back fetch with decode always ready
        for (int k = 0; k < 5; k++) begin
            check("seq_addr", o_imem_addr, 32'(4 * k));
            check("seq_req", 32'(o_imem_req), 32'd1);
            ack_push(32'(4 * k));
            cyc();
        end
        i_imem_ack = 1'b0;
        cyc();
        check("seq_next_addr", o_imem_addr, 32'h14);

        // Redirect while a request is pending without ack
        i_redirect = 1'b1; i_redirect_pc = 32'h100;
        cyc();
        i_redirect = 1'b0;
        check("drop_addr_held", o_imem_addr, 32'h14);
        check("drop_req", 32'(o_imem_req), 32'd1);
        cyc();
        check("drop_addr_held2", o_imem_addr, 32'h14);
        i_imem_ack = 1'b1; i_imem_rdata = 32'hBAD0_BAD0;
        cyc();
        i_imem_ack = 1'b0;
        check("drop_no_valid", 32'(o_if_valid), 32'd0);
        check("drop_new_addr", o_imem_addr, 32'h100);

        // Back-pressure fills both entries and stalls the request
        i_id_ready = 1'b0;
        ack_push(32'h100);
        cyc();
        check("bp_req1", 32'(o_imem_req), 32'd1);
        check("bp_addr1", o_imem_addr, 32'h104);
        ack_push(32'h104);
        cyc();
        i_imem_ack = 1'b0;
        check("bp_hold_req", 32'(o_imem_req), 32'd0);
        check("bp_valid", 32'(o_if_valid), 32'd1);
        check("bp_head_pc", o_if_pc, 32'h100);
        cyc();
        check("bp_hold_req2", 32'(o_imem_req), 32'd0);
        i_id_ready = 1'b1;
        cyc();
        check("bp_resume_req", 32'(o_imem_req), 32'd1);
        check("bp_resume_addr", o_imem_addr, 32'h108);
        check("bp_head_pc2", o_if_pc, 32'h104);

        // Redirect together with ack and pop flushes everything
        i_imem_ack = 1'b1; i_imem_rdata = instr_of(32'h108);
        i_redirect = 1'b1; i_redirect_pc = 32'h40;
        cyc();
        sb_q.delete();
        i_imem_ack = 1'b0; i_redirect = 1'b0;
        check("flush_valid", 32'(o_if_valid), 32'd0);
        check("flush_addr", o_imem_addr, 32'h40);
        check("flush_req", 32'(o_imem_req), 32'd1);

        // Two redirects during DROP: the latest one wins
        i_redirect = 1'b1; i_redirect_pc = 32'h80;
        cyc();
        i_redirect_pc = 32'hC0;
        cyc();
        i_redirect = 1'b0;
        check("drop2_addr_held", o_imem_addr, 32'h40);
        i_imem_ack = 1'b1; i_imem_rdata = 32'hDEAD_BEEF;
        cyc();
        i_imem_ack = 1'b0;
        check("drop2_addr", o_imem_addr, 32'hC0);
        check("drop2_valid", 32'(o_if_valid), 32'd0);

        // PC wraps past the top of the address space
        i_redirect = 1'b1; i_redirect_pc = 32'hFFFF_FFFC;
        cyc();
        i_redirect = 1'b0;
        i_imem_ack = 1'b1; i_imem_rdata = 32'h1234_5678;
        cyc();
        check("wrap_addr_pre", o_imem_addr, 32'hFFFF_FFFC);
        ack_push(32'hFFFF_FFFC);
        cyc();
        i_imem_ack = 1'b0;
        check("wrap_addr", o_imem_addr, 32'h0);
        check("wrap_head_pc", o_if_pc, 32'hFFFF_FFFC);

        // Reset with buffered entries and a request outstanding
        i_id_ready = 1'b0;
        ack_push(32'h0);
        cyc();
        i_imem_ack = 1'b0;
        check("pre_rst_hold", 32'(o_imem_req), 32'd0);
        i_id_ready = 1'b1;
        cyc();
        i_id_ready = 1'b0;
        check("pre_rst_req", 32'(o_imem_req), 32'd1);
        check("pre_rst_addr", o_imem_addr, 32'h4);
        check("pre_rst_valid", 32'(o_if_valid), 32'd1);
        #2;
        i_rst = 1'b1; i_imem_ack = 1'b1; i_imem_rdata = 32'h5555_AAAA;
        #1;
        check("mid_rst_req", 32'(o_imem_req), 32'd0);
        check("mid_rst_valid", 32'(o_if_valid), 32'd0);
        check("mid_rst_addr", o_imem_addr, 32'h0);
        check("mid_rst_instr", o_if_instr, 32'h0000_0013);
        sb_q.delete();
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        check("post_rst_req", 32'(o_imem_req), 32'd0);
        @(posedge i_clk);
        #1;
        i_imem_ack = 1'b0;
        check("post_rst_req2", 32'(o_imem_req), 32'd1);
        check("post_rst_addr", o_imem_addr, 32'h0);
        check("post_rst_valid", 32'(o_if_valid), 32'd0);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
